// File: rtl/div_arbiter.sv
// div_arbiter: shares one multi-cycle divider between two requesters.
// Optional one-entry result cache: define DIV_ARBITER_RESULT_CACHE_EN.
module div_arbiter #(
    parameter int FLUSH_CYCLES = 3,
    parameter bit FIXED_PRIO   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req_i,
    input  logic        r0_signed_i,
    input  logic [31:0] r0_opdata1_i,
    input  logic [31:0] r0_opdata2_i,
    input  logic        r0_annul_i,
    output logic        r0_done_o,
    output logic        r0_stall_o,
    input  logic        r1_req_i,
    input  logic        r1_signed_i,
    input  logic [31:0] r1_opdata1_i,
    input  logic [31:0] r1_opdata2_i,
    input  logic        r1_annul_i,
    output logic        r1_done_o,
    output logic        r1_stall_o,
    output logic [63:0] result_o,
    output logic        owner_o,
    output logic        busy_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE,
        S_FLUSH
`ifdef DIV_ARBITER_RESULT_CACHE_EN
        , S_HIT
`endif
    } state_t;

    state_t        r_state;
    logic          r_owner;
    logic          r_prio1;
    logic          r_done0;
    logic          r_done1;
    logic [63:0]   r_result;
    logic          r_signed;
    logic [31:0]   r_op1;
    logic [31:0]   r_op2;
    logic          r_start;
    logic          r_annul;
    logic [FW-1:0] r_flush;

    logic          w_cand0;
    logic          w_cand1;
    logic          w_grant;
    logic          w_pick1;
    logic          w_sel_signed;
    logic [31:0]   w_sel_op1;
    logic [31:0]   w_sel_op2;
    logic          w_own_annul;

    assign w_cand0 = r0_req_i & ~r0_annul_i;
    assign w_cand1 = r1_req_i & ~r1_annul_i;
    assign w_grant = w_cand0 | w_cand1;
    // Port 1 wins alone, or on a tie when round-robin favours it.
    assign w_pick1 = w_cand1 & (~w_cand0 | (~FIXED_PRIO & r_prio1));

    assign w_sel_signed = w_pick1 ? r1_signed_i  : r0_signed_i;
    assign w_sel_op1    = w_pick1 ? r1_opdata1_i : r0_opdata1_i;
    assign w_sel_op2    = w_pick1 ? r1_opdata2_i : r0_opdata2_i;

    assign w_own_annul = r_owner ? (r1_req_i & r1_annul_i)
                                 : (r0_req_i & r0_annul_i);

`ifdef DIV_ARBITER_RESULT_CACHE_EN
    logic        r_cv;
    logic        r_cs;
    logic [31:0] r_ca;
    logic [31:0] r_cb;
    logic [63:0] r_cres;
    logic        w_hit;

    assign w_hit = r_cv & (r_cs == w_sel_signed)
                 & (r_ca == w_sel_op1) & (r_cb == w_sel_op2);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_prio1  <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_result <= '0;
            r_signed <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_start  <= 1'b0;
            r_annul  <= 1'b0;
            r_flush  <= '0;
`ifdef DIV_ARBITER_RESULT_CACHE_EN
            r_cv     <= 1'b0;
            r_cs     <= 1'b0;
            r_ca     <= '0;
            r_cb     <= '0;
            r_cres   <= '0;
`endif
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
`ifdef DIV_ARBITER_RESULT_CACHE_EN
                    if (w_grant && w_hit) begin
                        r_owner <= w_pick1;
                        r_state <= S_HIT;
                    end else
`endif
                    if (w_grant) begin
                        r_owner  <= w_pick1;
                        r_signed <= w_sel_signed;
                        r_op1    <= w_sel_op1;
                        r_op2    <= w_sel_op2;
                        r_start  <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Annul outranks a result arriving in the same cycle.
                    if (w_own_annul) begin
                        r_start <= 1'b0;
                        r_annul <= 1'b1;
                        r_flush <= FW'(FLUSH_CYCLES - 1);
                        r_state <= S_FLUSH;
                    end else if (div_ready_i) begin
                        r_result <= div_result_i;
                        r_done0  <= ~r_owner;
                        r_done1  <= r_owner;
                        r_start  <= 1'b0;
                        r_state  <= S_RELEASE;
`ifdef DIV_ARBITER_RESULT_CACHE_EN
                        r_cv     <= 1'b1;
                        r_cs     <= r_signed;
                        r_ca     <= r_op1;
                        r_cb     <= r_op2;
                        r_cres   <= div_result_i;
`endif
                    end
                end
                S_RELEASE: begin
                    if (!div_ready_i) begin
                        r_prio1 <= ~r_owner;
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (r_flush == '0) begin
                        r_annul <= 1'b0;
                        r_prio1 <= ~r_owner;
                        r_state <= S_IDLE;
                    end else begin
                        r_flush <= r_flush - FW'(1);
                    end
                end
`ifdef DIV_ARBITER_RESULT_CACHE_EN
                S_HIT: begin
                    r_result <= r_cres;
                    r_done0  <= ~r_owner;
                    r_done1  <= r_owner;
                    r_prio1  <= ~r_owner;
                    r_state  <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign r0_done_o     = r_done0;
    assign r1_done_o     = r_done1;
    assign r0_stall_o    = r0_req_i & ~r_done0;
    assign r1_stall_o    = r1_req_i & ~r_done1;
    assign result_o      = r_result;
    assign owner_o       = r_owner;
    assign busy_o        = (r_state != S_IDLE);
    assign div_signed_o  = r_signed;
    assign div_opdata1_o = r_op1;
    assign div_opdata2_o = r_op2;
    assign div_start_o   = r_start;
    assign div_annul_o   = r_annul;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized bench with a divider model and a
// transaction-level arbitration/latency reference model.
`timescale 1ns/1ps
module tb_div_arbiter;
    localparam bit FIXED = 1'b0;
`ifdef DIV_ARBITER_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_signed, r0_annul, r0_done, r0_stall;
    logic [31:0] r0_op1, r0_op2;
    logic        r1_req, r1_signed, r1_annul, r1_done, r1_stall;
    logic [31:0] r1_op1, r1_op2;
    logic [63:0] result;
    logic        owner, busy;
    logic        div_signed, div_start, div_annul, div_ready;
    logic [31:0] div_op1, div_op2;
    logic [63:0] div_result;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cycles;

    // reference model state
    int          nxt;
    bit          cv, cs;
    logic [31:0] ca, cb;

    always #5 clk = ~clk;

    div_arbiter #(.FLUSH_CYCLES(3), .FIXED_PRIO(FIXED)) dut (
        .clk(clk), .rst(rst),
        .r0_req_i(r0_req), .r0_signed_i(r0_signed),
        .r0_opdata1_i(r0_op1), .r0_opdata2_i(r0_op2),
        .r0_annul_i(r0_annul), .r0_done_o(r0_done), .r0_stall_o(r0_stall),
        .r1_req_i(r1_req), .r1_signed_i(r1_signed),
        .r1_opdata1_i(r1_op1), .r1_opdata2_i(r1_op2),
        .r1_annul_i(r1_annul), .r1_done_o(r1_done), .r1_stall_o(r1_stall),
        .result_o(result), .owner_o(owner), .busy_o(busy),
        .div_signed_o(div_signed), .div_opdata1_o(div_op1),
        .div_opdata2_o(div_op2), .div_start_o(div_start),
        .div_annul_o(div_annul), .div_result_i(div_result),
        .div_ready_i(div_ready)
    );

    function automatic logic [63:0] ref_div(input logic s,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Companion divider: ready 35 edges after start seen (3 for /0).
    int dcnt;
    always @(posedge clk) begin
        if (rst || !div_start || div_annul) begin
            dcnt       <= 0;
            div_ready  <= 1'b0;
            div_result <= 64'hDEAD_BEEF_DEAD_BEEF;
        end else if (!div_ready) begin
            dcnt <= dcnt + 1;
            if (dcnt + 1 == ((div_op2 == 32'd0) ? 3 : 35)) begin
                div_ready  <= 1'b1;
                div_result <= ref_div(div_signed, div_op1, div_op2);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Edges from request set to done seen, counting the grant edge.
    function automatic int lat_of(input bit s, input logic [31:0] a,
                                  input logic [31:0] b);
        if (CACHE && cv && cs == s && ca == a && cb == b) return 2;
        return (b == 32'd0) ? 5 : 37;
    endfunction

    task automatic cache_put(input bit s, input logic [31:0] a,
                             input logic [31:0] b);
        cv = 1'b1;
        cs = s;
        ca = a;
        cb = b;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        r0_req = 0; r0_annul = 0; r1_req = 0; r1_annul = 0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_ctl"}, 64'({busy, owner, div_start, div_annul,
            div_signed, r0_done, r1_done, r0_stall, r1_stall}), 64'd0);
        chk({tag, "_result"}, result, 64'd0);
        chk({tag, "_ops"}, {div_op1, div_op2}, 64'd0);
        rst = 1'b0;
        nxt = 0;
        cv = 1'b0;
    endtask

    task automatic run_pair(input bit e0, input bit s0,
                            input logic [31:0] a0, input logic [31:0] b0,
                            input bit e1, input bit s1,
                            input logic [31:0] a1, input logic [31:0] b1);
        bit          en[2], sg[2], dn[2];
        logic [31:0] A[2], B[2];
        logic [63:0] ex[2];
        int          et[2];
        int          f, sp, l, t;
        bit          hitf;
        en[0] = e0; sg[0] = s0; A[0] = a0; B[0] = b0;
        en[1] = e1; sg[1] = s1; A[1] = a1; B[1] = b1;
        for (int p = 0; p < 2; p++) begin
            ex[p] = ref_div(sg[p], A[p], B[p]);
            et[p] = 0;
        end
        if (e0 && e1) f = FIXED ? 0 : nxt;
        else f = e0 ? 0 : 1;
        l = lat_of(sg[f], A[f], B[f]);
        et[f] = l;
        hitf = (l == 2);
        cache_put(sg[f], A[f], B[f]);
        nxt = 1 - f;
        if (e0 && e1) begin
            sp = 1 - f;
            l = lat_of(sg[sp], A[sp], B[sp]);
            et[sp] = et[f] + (hitf ? 1 : 3) + l - 1;
            cache_put(sg[sp], A[sp], B[sp]);
            nxt = 1 - sp;
        end
        r0_req = e0; r0_signed = s0; r0_op1 = a0; r0_op2 = b0;
        r1_req = e1; r1_signed = s1; r1_op1 = a1; r1_op2 = b1;
        dn[0] = !e0;
        dn[1] = !e1;
        t = 0;
        while (!(dn[0] && dn[1]) && t < 300) begin
            @(negedge clk);
            t++;
            start_cycles += int'(div_start);
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? r0_done : r1_done) begin
                    if (dn[p]) begin
                        chk($sformatf("r%0d_extra_done", p), 64'd1, 64'd0);
                    end else begin
                        chk($sformatf("r%0d_result", p), result, ex[p]);
                        chk($sformatf("r%0d_latency", p), 64'(t), 64'(et[p]));
                        if (!dn[1 - p])
                            chk($sformatf("r%0d_stall", 1 - p),
                                64'((p == 0) ? r1_stall : r0_stall), 64'd1);
                        dn[p] = 1'b1;
                        if (p == 0) r0_req = 1'b0;
                        else r1_req = 1'b0;
                    end
                end
            end
        end
        if (!(dn[0] && dn[1])) chk("done_timeout", 64'd0, 64'd1);
        r0_req = 1'b0;
        r1_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("tail_done", 64'({r0_done, r1_done}), 64'd0);
        end
        chk("tail_idle", 64'({busy, r0_stall, r1_stall}), 64'd0);
    endtask

    task automatic annul_test();
        int n_ann;
        r0_req = 1; r0_signed = 0; r0_op1 = 100; r0_op2 = 7;
        r0_annul = 0;
        repeat (11) begin
            @(negedge clk);
            chk("pre_annul_done", 64'(r0_done), 64'd0);
        end
        r0_annul = 1'b1;
        @(negedge clk);
        n_ann = int'(div_annul);
        chk("annul_stops_start", 64'(div_start), 64'd0);
        r0_req = 1'b0;
        r0_annul = 1'b0;
        repeat (60) begin
            @(negedge clk);
            n_ann += int'(div_annul);
            if (r0_done || r1_done) chk("annul_no_done", 64'd1, 64'd0);
        end
        chk("annul_cycles", 64'(n_ann), 64'd3);
        chk("annul_idle", 64'(busy), 64'd0);
        nxt = 1;
    endtask

    task automatic mid_reset_test();
        r1_req = 1; r1_signed = 0; r1_op1 = 1234; r1_op2 = 3;
        repeat (15) @(negedge clk);
        do_reset("midrst");
        run_pair(1, 0, 32'd50, 32'd5, 0, 0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] pa[2], pb[2];
        bit          ps[2];
        rst = 1'b1;
        r0_req = 0; r0_signed = 0; r0_op1 = 0; r0_op2 = 0; r0_annul = 0;
        r1_req = 0; r1_signed = 0; r1_op1 = 0; r1_op2 = 0; r1_annul = 0;
        start_cycles = 0;
        nxt = 0;
        cv = 0; cs = 0; ca = 0; cb = 0;
        do_reset("reset");

        run_pair(1, 0, 32'd100, 32'd7, 0, 0, 32'd0, 32'd0);
        chk("r0_100_7", result, 64'h00000002_0000000E);

        do_reset("reset2");
        run_pair(1, 1, -32'sd7, 32'd2, 1, 0, 32'd9, 32'd3);
        chk("r1_9_3", result, 64'h00000000_00000003);
        run_pair(1, 1, -32'sd7, 32'd2, 1, 0, 32'd9, 32'd3);

        run_pair(0, 0, 32'd0, 32'd0, 1, 0, 32'd5, 32'd0);
        annul_test();
        run_pair(0, 0, 32'd0, 32'd0, 1, 0, 32'd20, 32'd4);
        mid_reset_test();
        chk("r0_50_5", result, 64'h00000000_0000000A);

        for (int p = 0; p < 2; p++) begin
            ps[p] = 0; pa[p] = 1; pb[p] = 1;
        end
        for (int it = 0; it < 24; it++) begin
            bit en[2];
            en[0] = 1'($urandom % 2);
            en[1] = 1'($urandom % 2);
            if (!en[0] && !en[1]) en[0] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                if ($urandom % 4 != 0) begin
                    ps[p] = 1'($urandom % 2);
                    pa[p] = $urandom;
                    if ($urandom % 6 == 0) pb[p] = 32'd0;
                    else if ($urandom % 2 == 0) pb[p] = $urandom;
                    else pb[p] = 32'($urandom % 50 + 1);
                end
            end
            run_pair(en[0], ps[0], pa[0], pb[0], en[1], ps[1], pa[1], pb[1]);
        end

`ifdef DIV_ARBITER_RESULT_CACHE_EN
        do_reset("reset_cache");
        run_pair(1, 0, 32'd100, 32'd7, 0, 0, 32'd0, 32'd0);
        start_cycles = 0;
        run_pair(1, 0, 32'd100, 32'd7, 0, 0, 32'd0, 32'd0);
        chk("hit_no_start", 64'(start_cycles), 64'd0);
        chk("hit_result", result, 64'h00000002_0000000E);
        run_pair(1, 1, 32'd100, 32'd7, 0, 0, 32'd0, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
